// File: rtl/miriscv_fetch_stage.sv
// Fetch stage: credit-limited in-order instruction requests feeding a DEPTH-entry {pc, instr} buffer.
// Responses become visible one cycle after rvalid. Requests stop when in-flight plus buffered entries reach DEPTH.
module miriscv_fetch_stage #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned ILEN      = 32,
  parameter logic [XLEN-1:0] BOOT_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH     = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  output logic            instr_req_o,
  output logic [XLEN-1:0] instr_addr_o,
  input  logic            instr_gnt_i,
  input  logic            instr_rvalid_i,
  input  logic [ILEN-1:0] instr_rdata_i,
  input  logic [XLEN-1:0] cu_pc_bra_i,
  input  logic            cu_boot_addr_load_en_i,
  input  logic            cu_stall_f_i,
  input  logic            cu_kill_f_i,
  output logic [ILEN-1:0] f_instr_o,
  output logic [XLEN-1:0] f_current_pc_o,
  output logic [XLEN-1:0] f_next_pc_o,
  output logic            f_valid_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] CAP = (CW+1)'(DEPTH);
  localparam logic [ILEN-1:0] NOP = ILEN'(32'h0000_0013);

  logic [XLEN-1:0] req_pc;
  logic [XLEN-1:0] resp_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   discard;
  logic [CW-1:0]   fifo_count;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [ILEN-1:0] instr_mem [DEPTH];

  logic          kill;
  logic          pop;
  logic          rsp;
  logic          issue;
  logic          push;
  logic          redirect;
  logic [CW:0]   credit_used;

  assign f_valid_o   = (fifo_count != '0);
  assign pop         = f_valid_o & ~cu_stall_f_i;
  assign kill        = cu_kill_f_i & ~cu_stall_f_i;
  assign redirect    = cu_boot_addr_load_en_i | kill;
  // Responses with nothing outstanding are protocol errors and are ignored.
  assign rsp         = instr_rvalid_i & (outstanding != '0);
  assign credit_used = {1'b0, outstanding} + {1'b0, fifo_count} - {{CW{1'b0}}, pop};

  assign instr_req_o  = ~rst_i & ~redirect & (credit_used < CAP);
  assign instr_addr_o = req_pc;
  assign issue        = instr_req_o & instr_gnt_i;
  assign push         = rsp & (discard == '0) & ~rst_i & ~redirect;

  assign f_instr_o      = f_valid_o ? instr_mem[rd_ptr] : NOP;
  assign f_current_pc_o = f_valid_o ? pc_mem[rd_ptr] : resp_pc;
  assign f_next_pc_o    = f_current_pc_o + XLEN'(4);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_pc      <= BOOT_ADDR;
      resp_pc     <= BOOT_ADDR;
      outstanding <= '0;
      discard     <= '0;
      fifo_count  <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else if (redirect) begin
      // Every response still in flight belongs to the old stream and must be dropped.
      req_pc      <= cu_boot_addr_load_en_i ? BOOT_ADDR : cu_pc_bra_i;
      resp_pc     <= cu_boot_addr_load_en_i ? BOOT_ADDR : cu_pc_bra_i;
      outstanding <= outstanding - CW'(rsp);
      discard     <= outstanding - CW'(rsp);
      fifo_count  <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      if (issue) req_pc <= req_pc + XLEN'(4);
      outstanding <= outstanding + CW'(issue) - CW'(rsp);
      if (rsp && discard != '0) discard <= discard - CW'(1);
      if (push) begin
        resp_pc <= resp_pc + XLEN'(4);
        wr_ptr  <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem[wr_ptr]    <= resp_pc;
      instr_mem[wr_ptr] <= instr_rdata_i;
    end
  end

endmodule

// File: tb/tb_miriscv_fetch_stage.sv
// Directed bench for miriscv_fetch_stage with a 1-cycle in-order memory model.
module tb_miriscv_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i = 1'b1;
  logic        instr_rvalid_i = 1'b0;
  logic [31:0] instr_rdata_i = 32'h0;
  logic [31:0] cu_pc_bra_i = 32'h0;
  logic        cu_boot_addr_load_en_i = 1'b0;
  logic        cu_stall_f_i = 1'b0;
  logic        cu_kill_f_i = 1'b0;
  logic [31:0] f_instr_o;
  logic [31:0] f_current_pc_o;
  logic [31:0] f_next_pc_o;
  logic        f_valid_o;
  logic        mem_hold = 1'b0;

  logic        w_rst = 1'b1;
  logic        w_req;
  logic [31:0] w_addr;
  logic [31:0] w_instr;
  logic [31:0] w_cur;
  logic [31:0] w_next;
  logic        w_valid;

  int checks = 0;
  int failures = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  always #5 clk = ~clk;

  miriscv_fetch_stage u_dut (
    .clk_i(clk), .rst_i(rst_i),
    .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o), .instr_gnt_i(instr_gnt_i),
    .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i),
    .cu_pc_bra_i(cu_pc_bra_i), .cu_boot_addr_load_en_i(cu_boot_addr_load_en_i),
    .cu_stall_f_i(cu_stall_f_i), .cu_kill_f_i(cu_kill_f_i),
    .f_instr_o(f_instr_o), .f_current_pc_o(f_current_pc_o), .f_next_pc_o(f_next_pc_o),
    .f_valid_o(f_valid_o)
  );

  miriscv_fetch_stage #(.BOOT_ADDR(32'hFFFF_FFF8)) u_wrap (
    .clk_i(clk), .rst_i(w_rst),
    .instr_req_o(w_req), .instr_addr_o(w_addr), .instr_gnt_i(1'b1),
    .instr_rvalid_i(1'b0), .instr_rdata_i(32'h0),
    .cu_pc_bra_i(32'h0), .cu_boot_addr_load_en_i(1'b0),
    .cu_stall_f_i(1'b0), .cu_kill_f_i(1'b0),
    .f_instr_o(w_instr), .f_current_pc_o(w_cur), .f_next_pc_o(w_next),
    .f_valid_o(w_valid)
  );

  function automatic logic [31:0] dat(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Memory: a grant seen before edge k is answered with rvalid sampled at edge k+1.
  logic [31:0] mq[$];
  always @(negedge clk) begin
    if (rst_i) begin
      mq.delete();
      instr_rvalid_i = 1'b0;
    end else begin
      if (!mem_hold && mq.size() > 0) begin
        instr_rvalid_i = 1'b1;
        instr_rdata_i  = dat(mq.pop_front());
      end else begin
        instr_rvalid_i = 1'b0;
      end
      if (instr_req_o && instr_gnt_i) mq.push_back(instr_addr_o);
    end
  end

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  task automatic restart;
    step;
    rst_i = 1'b1; cu_boot_addr_load_en_i = 1'b0; cu_stall_f_i = 1'b0; cu_kill_f_i = 1'b0;
    instr_gnt_i = 1'b1; mem_hold = 1'b0;
    step; step;
    rst_i = 1'b0;
  endtask

  task automatic test_reset;
    step; step; smp;
    checks++; if (instr_req_o !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", instr_req_o); end
    checks++; if (f_valid_o !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", f_valid_o); end
    checks++; if (f_instr_o !== NOP) begin failures++; $display("FAIL rst_instr got=%h exp=%h", f_instr_o, NOP); end
    checks++; if (f_current_pc_o !== 32'h0) begin failures++; $display("FAIL rst_pc got=%h exp=0", f_current_pc_o); end
    checks++; if (f_next_pc_o !== 32'h4) begin failures++; $display("FAIL rst_next got=%h exp=4", f_next_pc_o); end
    checks++; if (w_cur !== 32'hFFFF_FFF8) begin failures++; $display("FAIL rst_wrap_pc got=%h exp=fffffff8", w_cur); end
    checks++; if (w_next !== 32'hFFFF_FFFC) begin failures++; $display("FAIL rst_wrap_next got=%h exp=fffffffc", w_next); end
  endtask

  task automatic test_boot;
    step; rst_i = 1'b0; cu_boot_addr_load_en_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      if (i > 0) step;
      smp;
      checks++; if (instr_req_o !== 1'b0) begin failures++; $display("FAIL boot_req%0d got=%b exp=0", i, instr_req_o); end
    end
    step; cu_boot_addr_load_en_i = 1'b0;
    smp;
    checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h0) begin failures++; $display("FAIL boot_first_req req=%b addr=%h exp 1/0", instr_req_o, instr_addr_o); end
    step; smp;
    checks++; if (f_valid_o !== 1'b0) begin failures++; $display("FAIL boot_no_bypass got=%b exp=0", f_valid_o); end
    for (int i = 0; i < 3; i++) begin
      step; smp;
      checks++;
      if (f_valid_o !== 1'b1 || f_current_pc_o !== 32'(4*i) || f_instr_o !== dat(32'(4*i)) || f_next_pc_o !== 32'(4*i+4)) begin
        failures++; $display("FAIL boot_seq%0d v=%b pc=%h instr=%h next=%h exp_pc=%h", i, f_valid_o, f_current_pc_o, f_instr_o, f_next_pc_o, 32'(4*i));
      end
    end
  endtask

  task automatic test_stall;
    step; cu_stall_f_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step;
      smp;
      checks++; if (f_valid_o !== 1'b1 || f_current_pc_o !== 32'hC) begin failures++; $display("FAIL stall_hold%0d v=%b pc=%h exp=c", i, f_valid_o, f_current_pc_o); end
    end
    checks++; if (instr_req_o !== 1'b0) begin failures++; $display("FAIL stall_credit_full req=%b exp=0", instr_req_o); end
    step; cu_stall_f_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step;
      smp;
      checks++;
      if (f_valid_o !== 1'b1 || f_current_pc_o !== 32'(12 + 4*i) || f_instr_o !== dat(32'(12 + 4*i))) begin
        failures++; $display("FAIL stall_release%0d v=%b pc=%h instr=%h exp_pc=%h", i, f_valid_o, f_current_pc_o, f_instr_o, 32'(12 + 4*i));
      end
    end
  endtask

  task automatic test_kill;
    restart;
    repeat (5) step;
    step; cu_kill_f_i = 1'b1; cu_pc_bra_i = 32'h100; mem_hold = 1'b1;
    smp;
    checks++; if (f_valid_o !== 1'b1 || f_current_pc_o !== 32'h10) begin failures++; $display("FAIL kill_jump_head v=%b pc=%h exp=10", f_valid_o, f_current_pc_o); end
    checks++; if (instr_req_o !== 1'b0) begin failures++; $display("FAIL kill_no_req got=%b exp=0", instr_req_o); end
    step; cu_kill_f_i = 1'b0; mem_hold = 1'b0;
    smp;
    checks++; if (f_valid_o !== 1'b0) begin failures++; $display("FAIL kill_flush v=%b exp=0", f_valid_o); end
    checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h100) begin failures++; $display("FAIL kill_target_req req=%b addr=%h exp 1/100", instr_req_o, instr_addr_o); end
    step; smp;
    checks++; if (f_valid_o !== 1'b0 || f_current_pc_o !== 32'h100) begin failures++; $display("FAIL kill_stale_dropped v=%b pc=%h exp 0/100", f_valid_o, f_current_pc_o); end
    step; smp;
    checks++; if (f_valid_o !== 1'b1 || f_current_pc_o !== 32'h100 || f_instr_o !== dat(32'h100)) begin failures++; $display("FAIL kill_target v=%b pc=%h instr=%h exp pc=100", f_valid_o, f_current_pc_o, f_instr_o); end
    step; smp;
    checks++; if (f_valid_o !== 1'b1 || f_current_pc_o !== 32'h104) begin failures++; $display("FAIL kill_target_next v=%b pc=%h exp=104", f_valid_o, f_current_pc_o); end
  endtask

  task automatic test_kill_stall;
    restart;
    repeat (5) step;
    step; cu_stall_f_i = 1'b1; cu_kill_f_i = 1'b1; cu_pc_bra_i = 32'h200;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step;
      smp;
      checks++; if (f_valid_o !== 1'b1 || f_current_pc_o !== 32'h10) begin failures++; $display("FAIL ks_hold%0d v=%b pc=%h exp=10", i, f_valid_o, f_current_pc_o); end
    end
    step; cu_stall_f_i = 1'b0;
    smp;
    checks++; if (f_current_pc_o !== 32'h10 || instr_req_o !== 1'b0) begin failures++; $display("FAIL ks_kill_cycle pc=%h req=%b exp 10/0", f_current_pc_o, instr_req_o); end
    step; cu_kill_f_i = 1'b0;
    smp;
    checks++; if (f_valid_o !== 1'b0 || instr_req_o !== 1'b1 || instr_addr_o !== 32'h200) begin failures++; $display("FAIL ks_target_req v=%b req=%b addr=%h exp 0/1/200", f_valid_o, instr_req_o, instr_addr_o); end
    step; smp;
    checks++; if (f_valid_o !== 1'b0) begin failures++; $display("FAIL ks_empty v=%b exp=0", f_valid_o); end
    step; smp;
    checks++; if (f_valid_o !== 1'b1 || f_current_pc_o !== 32'h200 || f_instr_o !== dat(32'h200)) begin failures++; $display("FAIL ks_target v=%b pc=%h instr=%h exp pc=200", f_valid_o, f_current_pc_o, f_instr_o); end
  endtask

  task automatic test_gnt_backpressure;
    restart;
    repeat (8) step;
    instr_gnt_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step;
      smp;
      checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h20) begin failures++; $display("FAIL gnt_hold%0d req=%b addr=%h exp 1/20", i, instr_req_o, instr_addr_o); end
    end
    checks++; if (f_valid_o !== 1'b0 || f_current_pc_o !== 32'h20) begin failures++; $display("FAIL gnt_drained v=%b pc=%h exp 0/20", f_valid_o, f_current_pc_o); end
    step; instr_gnt_i = 1'b1;
    smp;
    checks++; if (instr_addr_o !== 32'h20) begin failures++; $display("FAIL gnt_accept addr=%h exp=20", instr_addr_o); end
    step; smp;
    checks++; if (instr_addr_o !== 32'h24) begin failures++; $display("FAIL gnt_single addr=%h exp=24", instr_addr_o); end
    step; smp;
    checks++; if (f_valid_o !== 1'b1 || f_current_pc_o !== 32'h20 || f_instr_o !== dat(32'h20)) begin failures++; $display("FAIL gnt_data v=%b pc=%h instr=%h exp pc=20", f_valid_o, f_current_pc_o, f_instr_o); end
  endtask

  task automatic test_reset_mid;
    restart;
    repeat (6) step;
    rst_i = 1'b1;
    step; smp;
    checks++;
    if (instr_req_o !== 1'b0 || f_valid_o !== 1'b0 || f_instr_o !== NOP || f_current_pc_o !== 32'h0 || f_next_pc_o !== 32'h4) begin
      failures++; $display("FAIL mid_reset req=%b v=%b instr=%h pc=%h next=%h exp 0/0/13/0/4", instr_req_o, f_valid_o, f_instr_o, f_current_pc_o, f_next_pc_o);
    end
    step; rst_i = 1'b0;
    smp;
    checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h0) begin failures++; $display("FAIL mid_restart_req req=%b addr=%h exp 1/0", instr_req_o, instr_addr_o); end
    step; step; smp;
    checks++; if (f_valid_o !== 1'b1 || f_current_pc_o !== 32'h0 || f_instr_o !== dat(32'h0)) begin failures++; $display("FAIL mid_restart_head v=%b pc=%h instr=%h exp pc=0", f_valid_o, f_current_pc_o, f_instr_o); end
  endtask

  task automatic test_wrap;
    logic [31:0] exp_addr [4];
    exp_addr[0] = 32'hFFFF_FFF8; exp_addr[1] = 32'hFFFF_FFFC;
    exp_addr[2] = 32'h0000_0000; exp_addr[3] = 32'h0000_0004;
    step; w_rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step;
      smp;
      checks++; if (w_req !== 1'b1 || w_addr !== exp_addr[i]) begin failures++; $display("FAIL wrap_addr%0d req=%b addr=%h exp=%h", i, w_req, w_addr, exp_addr[i]); end
    end
    step; smp;
    checks++; if (w_req !== 1'b0) begin failures++; $display("FAIL wrap_credit req=%b exp=0", w_req); end
  endtask

  initial begin
    test_reset;
    test_boot;
    test_stall;
    test_kill;
    test_kill_stall;
    test_gnt_backpressure;
    test_reset_mid;
    test_wrap;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
